sdram_init_refresh: RTL and testbench
=====================================

# sdram_init_refresh

Power-up initialisation sequencer and periodic auto-refresh request generator for the SDRAM controller. After reset it issues the JEDEC init sequence directly on the command/address outputs: power-up wait, PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER. It then raises `init_done` and produces a counted refresh-request stream that the command arbiter consumes. All inter-command delays come from one internal wait counter.

## Interface
- `ADDR_W`, 13: SDRAM address width.
- `T_POWERUP`, 20000: cycles from reset release to the PRECHARGE ALL command.
- `T_RP`, 3: PRECHARGE to next command, in cycles.
- `T_RFC`, 9: AUTO REFRESH to next command, in cycles.
- `T_MRD`, 2: LOAD MODE REGISTER to `init_done`, in cycles.
- `INIT_REFRESHES`, 8: number of AUTO REFRESH commands during init (≥1).
- `T_REFI`, 1560: refresh interval in cycles.
- `PEND_MAX`, 7: saturation value of the pending-refresh counter.
- `MODE_REG`, 13'h0033: mode word. CAS 3, sequential, BL8.
- `TW`, 16: wait-counter width. Must hold max(T_POWERUP, T_REFI).

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `cke_o` out 1: SDRAM CKE.
- `cmd_o` out 4: {cs_n, ras_n, cas_n, we_n}, registered.
- `addr_o` out ADDR_W: SDRAM address, registered.
- `ba_o` out 2: bank address, registered.
- `init_done` out 1: init complete, sticky.
- `ref_req` out 1: high while at least one refresh is pending.
- `ref_ack` in 1: one-cycle pulse; the arbiter has issued one AUTO REFRESH.
- `ref_pending` out 3: pending-refresh count.
- `ref_overflow` out 1: sticky; a tick arrived while the count was at PEND_MAX.

## Operation
- Command encodings:
  - INHIBIT 1111
  - NOP 0111
  - PRECHARGE 0010, with A10=1
  - AUTO REFRESH 0001
  - LOAD MODE 0000, with addr=MODE_REG and ba=0
- FSM states and transitions:
  - PWR_WAIT → PRECH when wait done.
  - PRECH → RP_WAIT after 1 cycle.
  - RP_WAIT → AREF when wait done.
  - AREF → RFC_WAIT after 1 cycle.
  - RFC_WAIT → AREF if refresh count < INIT_REFRESHES, else → LMR, when wait done.
  - LMR → MRD_WAIT after 1 cycle.
  - MRD_WAIT → DONE when wait done.
  - DONE is terminal until reset.
- Command states (PRECH, AREF, LMR):
  - drive their command for exactly one cycle;
  - clear the wait counter;
  - load the counter period with the following delay minus 1.
- Outside command cycles `cmd_o` = INHIBIT until the first command, NOP afterwards. `addr_o` and `ba_o` are 0 outside command cycles.
- Wait counter: counts up to the loaded period and holds there. "Done" when count ≥ period. No wrap.
- Init refresh counter: incremented in AREF, `$clog2(INIT_REFRESHES+1)` bits.
- In DONE the wait counter is reused as the refresh-interval timer:
  - period T_REFI−1;
  - on reaching the period it emits a one-cycle tick and restarts.
- Pending counter, per cycle:
  - tick only: +1, saturating at PEND_MAX. A tick at PEND_MAX sets `ref_overflow`.
  - `ref_ack` only with pending > 0: −1.
  - tick and ack in the same cycle: unchanged. If pending = PEND_MAX the tick is still counted as absorbed, so no overflow.
  - ack with pending = 0: ignored.
- `ref_req` = (pending ≠ 0).
- `ref_ack` before `init_done` is ignored.

## Timing
- Reset values:
  - `cke_o`=0
  - `cmd_o`=1111
  - `addr_o`=0, `ba_o`=0
  - `init_done`=0, `ref_req`=0, `ref_pending`=0, `ref_overflow`=0
  - FSM in PWR_WAIT, counters 0
- Cycle 1 is the first rising edge after RST deasserts.
- Required cycle positions:
  - `cke_o` rises at cycle 1.
  - PRECHARGE at cycle T_POWERUP.
  - First AREF at T_POWERUP+T_RP.
  - Each next AREF T_RFC after the previous one.
  - LMR T_RFC after the last AREF.
  - `init_done` rises T_MRD after LMR.
- Refresh ticks: the first `ref_pending` increment is visible T_REFI cycles after `init_done` rises, then every T_REFI cycles.
- `ref_req` rises in the same cycle as the pending count becomes nonzero.
- `ref_req` falls on the cycle after the ack that brings the count to 0.
- RST mid-sequence: immediate return to reset values. The full sequence, including the power-up wait, restarts.

## Structure
- Shared package `sdram_pkg` holds:
  - command encodings CMD_INHIBIT, CMD_NOP, CMD_PRECHARGE, CMD_AREF, CMD_LMR;
  - the FSM state enum;
  - the A10 bit index.
- One sub-module, `wait_counter`: inputs TW-bit `period` and `restart`; outputs `count` and `done` (count ≥ period); saturating. It is instantiated once and shared between init waits and refresh interval.

## Test plan
Small parameters used by all scenarios: T_POWERUP=10, T_RP=3, T_RFC=5, T_MRD=2, INIT_REFRESHES=2, T_REFI=20, PEND_MAX=3.

- Init sequence:
  - PRECHARGE (0010, A10=1) at cycle 10;
  - AREF at 13 and 18;
  - LMR with addr=0x0033 at 23;
  - `init_done` at 25;
  - every other cycle after 10 is NOP, every cycle before 10 is INHIBIT, `cke_o`=1 from cycle 1.
- Refresh ticks with no ack: pending = 1, 2, 3 at cycles 45, 65, 85. At 105 pending stays 3 and `ref_overflow`=1.
- Ack on the same cycle as the tick at 65: pending stays 1 and `ref_req` stays high. A further ack drops `ref_req` on the next cycle.
- `ref_ack` at pending=0, and `ref_ack` before `init_done`: no change to any output.
- RST asserted at cycle 16, between the AREFs: all outputs return to reset values immediately. After release, PRECHARGE occurs 10 cycles later and the whole sequence repeats.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg
//   Shared definitions for the SDRAM controller slice: command encodings
//   ({cs_n, ras_n, cas_n, we_n}), the init sequencer state enum and the
//   address bit that selects "all banks" on PRECHARGE.
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    // A10 high on PRECHARGE closes every bank.
    localparam int A10_BIT = 10;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        PRECH    = 3'd1,
        RP_WAIT  = 3'd2,
        AREF     = 3'd3,
        RFC_WAIT = 3'd4,
        LMR      = 3'd5,
        MRD_WAIT = 3'd6,
        DONE     = 3'd7
    } init_state_e;

endpackage

// File: rtl/wait_counter.sv
// wait_counter
//   Saturating up-counter used for every inter-command delay and for the
//   refresh interval. It counts up to `period` and holds there; `done` is
//   high whenever count >= period. `restart` forces the count to 0 on the
//   next edge and has priority over counting.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   period     terminal count (TW bits)
//   restart    clear request
//   count      current count
//   done       count >= period
module wait_counter #(
    parameter int TW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [TW-1:0] period,
    input  logic          restart,
    output logic [TW-1:0] count,
    output logic          done
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (count_q < period) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q >= period);

endmodule

// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh
//   Power-up init sequencer (power-up wait, PRECHARGE ALL, N x AUTO
//   REFRESH, LOAD MODE) driving the SDRAM pins directly, followed by a
//   periodic refresh-request generator with a saturating pending count.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   cke_o             SDRAM CKE, high from the first edge after reset
//   cmd_o             {cs_n, ras_n, cas_n, we_n}, registered
//   addr_o, ba_o      SDRAM address / bank, registered, 0 outside commands
//   init_done         sticky, init sequence finished
//   ref_req/ref_ack   refresh handshake (see below)
//   ref_pending       number of refreshes owed
//   ref_overflow      sticky, an interval tick was lost at saturation
//   dbg_state_o       current sequencer state
//   dbg_wait_count_o  current wait-counter value
//
// Refresh handshake: ref_req is high whenever ref_pending != 0. The arbiter
// pulses ref_ack for one cycle per AUTO REFRESH it issues; each accepted ack
// removes one pending refresh. Acks with nothing pending, or before
// init_done, are ignored.
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int                ADDR_W         = 13,
    parameter int                T_POWERUP      = 20000,
    parameter int                T_RP           = 3,
    parameter int                T_RFC          = 9,
    parameter int                T_MRD          = 2,
    parameter int                INIT_REFRESHES = 8,
    parameter int                T_REFI         = 1560,
    parameter int                PEND_MAX       = 7,
    parameter logic [ADDR_W-1:0] MODE_REG       = 13'h0033,
    parameter int                TW             = 16
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              cke_o,
    output logic [3:0]        cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        ba_o,
    output logic              init_done,
    output logic              ref_req,
    input  logic              ref_ack,
    output logic [2:0]        ref_pending,
    output logic              ref_overflow,
    output logic [2:0]        dbg_state_o,
    output logic [TW-1:0]     dbg_wait_count_o
);

    localparam int RCW = $clog2(INIT_REFRESHES + 1);

    init_state_e       state_q, state_d;
    logic [RCW-1:0]    ref_cnt_q, ref_cnt_d;
    logic [TW-1:0]     period_q, period_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        ba_q, ba_d;
    logic              cke_q;
    logic              init_done_q, init_done_d;
    logic [2:0]        pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic              wait_done;
    logic              restart;
    logic              tick;
    logic              ack_eff;

    wait_counter #(.TW(TW)) u_wait (
        .CLK     (CLK),
        .RST     (RST),
        .period  (period_q),
        .restart (restart),
        .count   (dbg_wait_count_o),
        .done    (wait_done)
    );

    // In DONE the wait counter doubles as the refresh-interval timer.
    assign tick    = (state_q == DONE) && wait_done;
    assign ack_eff = ref_ack && init_done_q && (pend_q != 3'd0);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PWR_WAIT: if (wait_done) state_d = PRECH;
            PRECH:    state_d = RP_WAIT;
            RP_WAIT:  if (wait_done) state_d = AREF;
            AREF:     state_d = RFC_WAIT;
            RFC_WAIT: if (wait_done) state_d = (ref_cnt_q < RCW'(INIT_REFRESHES)) ? AREF : LMR;
            LMR:      state_d = MRD_WAIT;
            MRD_WAIT: if (wait_done) state_d = DONE;
            DONE:     state_d = DONE;
            default:  state_d = PWR_WAIT;
        endcase
    end

    // Outputs and counter control. Commands are decoded from the next state
    // so the registered pins change on the same edge the FSM enters the
    // command state; the wait counter is cleared on that same edge, which
    // is why each loaded period is the following delay minus 1.
    always_comb begin
        cmd_d     = (state_d == PWR_WAIT) ? CMD_INHIBIT : CMD_NOP;
        addr_d    = '0;
        ba_d      = '0;
        period_d  = period_q;
        restart   = tick;
        ref_cnt_d = ref_cnt_q + ((state_q == AREF) ? RCW'(1) : RCW'(0));
        init_done_d = init_done_q || (state_d == DONE);

        case (state_d)
            PRECH: begin
                cmd_d           = CMD_PRECHARGE;
                addr_d[A10_BIT] = 1'b1;
            end
            AREF:    cmd_d = CMD_AREF;
            LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = MODE_REG;
            end
            default: ;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                PRECH: begin restart = 1'b1; period_d = TW'(T_RP - 1);   end
                AREF:  begin restart = 1'b1; period_d = TW'(T_RFC - 1);  end
                LMR:   begin restart = 1'b1; period_d = TW'(T_MRD - 1);  end
                DONE:  begin restart = 1'b1; period_d = TW'(T_REFI - 1); end
                default: ;
            endcase
        end
    end

    // Pending-refresh counter. A tick that coincides with an accepted ack
    // cancels out, even at saturation, so it never counts as an overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !ack_eff) begin
            if (pend_q == 3'(PEND_MAX)) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 3'd1;
            end
        end else if (ack_eff && !tick) begin
            pend_d = pend_q - 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= PWR_WAIT;
            ref_cnt_q   <= '0;
            period_q    <= TW'(T_POWERUP - 1);
            cmd_q       <= CMD_INHIBIT;
            addr_q      <= '0;
            ba_q        <= '0;
            cke_q       <= 1'b0;
            init_done_q <= 1'b0;
            pend_q      <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            period_q    <= period_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            cke_q       <= 1'b1;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cke_o        = cke_q;
    assign cmd_o        = cmd_q;
    assign addr_o       = addr_q;
    assign ba_o         = ba_q;
    assign init_done    = init_done_q;
    assign ref_req      = (pend_q != 3'd0);
    assign ref_pending  = pend_q;
    assign ref_overflow = ovf_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// tb_sdram_init_refresh
//   Bench for sdram_init_refresh with small timing parameters. Expected
//   command events and refresh-counter states are pushed into queues before
//   the cycles run and popped as the DUT produces them.
module tb_sdram_init_refresh;
    import sdram_pkg::*;

    localparam int ADDR_W         = 13;
    localparam int T_POWERUP      = 10;
    localparam int T_RP           = 3;
    localparam int T_RFC          = 5;
    localparam int T_MRD          = 2;
    localparam int INIT_REFRESHES = 2;
    localparam int T_REFI         = 20;
    localparam int PEND_MAX       = 3;
    localparam int TW             = 16;
    localparam logic [ADDR_W-1:0] MODE_REG = 13'h0033;

    // Cycle at which init_done is expected to rise.
    localparam int DONE_CYC = T_POWERUP + T_RP + INIT_REFRESHES * T_RFC + T_MRD;

    localparam int W  = 35; // {cycle[15:0], cmd, addr, ba}
    localparam int RW = 21; // {cycle[15:0], pending, req, overflow}

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ref_ack = 1'b0;

    always #5 CLK = ~CLK;

    logic              cke_o;
    logic [3:0]        cmd_o;
    logic [ADDR_W-1:0] addr_o;
    logic [1:0]        ba_o;
    logic              init_done;
    logic              ref_req;
    logic [2:0]        ref_pending;
    logic              ref_overflow;
    logic [2:0]        dbg_state_o;
    logic [TW-1:0]     dbg_wait_count_o;

    sdram_init_refresh #(
        .ADDR_W         (ADDR_W),
        .T_POWERUP      (T_POWERUP),
        .T_RP           (T_RP),
        .T_RFC          (T_RFC),
        .T_MRD          (T_MRD),
        .INIT_REFRESHES (INIT_REFRESHES),
        .T_REFI         (T_REFI),
        .PEND_MAX       (PEND_MAX),
        .MODE_REG       (MODE_REG),
        .TW             (TW)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .cke_o            (cke_o),
        .cmd_o            (cmd_o),
        .addr_o           (addr_o),
        .ba_o             (ba_o),
        .init_done        (init_done),
        .ref_req          (ref_req),
        .ref_ack          (ref_ack),
        .ref_pending      (ref_pending),
        .ref_overflow     (ref_overflow),
        .dbg_state_o      (dbg_state_o),
        .dbg_wait_count_o (dbg_wait_count_o)
    );

    // ---------------- scoreboard state ----------------
    int cyc;
    int checks;
    int errors;
    logic [W-1:0]  exp_q[$];
    logic [RW-1:0] ref_q[$];
    int            ack_at[$];   // edge numbers at which ref_ack is sampled high

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        RST     = 1'b1;
        ref_ack = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
    endtask

    function automatic bit in_plan(input int c);
        foreach (ack_at[i]) if (ack_at[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Runs from reset release to init_done, checking every cycle. With
    // random_ack set, ref_ack is toggled randomly before init completes.
    task automatic run_init(input bit random_ack);
        logic [W-1:0]      got;
        logic [W-1:0]      exp;
        logic [ADDR_W-1:0] a10;
        int                lmr_c;
        a10          = '0;
        a10[A10_BIT] = 1'b1;
        exp_q.delete();
        exp_q.push_back({16'(T_POWERUP), CMD_PRECHARGE, a10, 2'b00});
        for (int i = 0; i < INIT_REFRESHES; i++) begin
            exp_q.push_back({16'(T_POWERUP + T_RP + i * T_RFC), CMD_AREF, 13'd0, 2'b00});
        end
        lmr_c = T_POWERUP + T_RP + INIT_REFRESHES * T_RFC;
        exp_q.push_back({16'(lmr_c), CMD_LMR, MODE_REG, 2'b00});

        while (cyc < DONE_CYC) begin
            ref_ack = random_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            ref_ack = 1'b0;
            checks++;
            if (cke_o !== 1'b1) begin
                errors++;
                $display("FAIL init_cke cycle %0d: got %b expected 1", cyc, cke_o);
            end
            if (cmd_o !== CMD_NOP && cmd_o !== CMD_INHIBIT) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL init_unexpected_cmd cycle %0d: got cmd %b", cyc, cmd_o);
                end else begin
                    exp = exp_q.pop_front();
                    got = {16'(cyc), cmd_o, addr_o, ba_o};
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL init_cmd cycle %0d: got %h expected %h", cyc, got, exp);
                    end
                end
            end else begin
                checks++;
                if ({cmd_o, addr_o, ba_o} !== {((cyc < T_POWERUP) ? CMD_INHIBIT : CMD_NOP), 13'd0, 2'b00}) begin
                    errors++;
                    $display("FAIL init_idle cycle %0d: got cmd %b addr %h ba %b", cyc, cmd_o, addr_o, ba_o);
                end
            end
            checks++;
            if (init_done !== (cyc >= DONE_CYC)) begin
                errors++;
                $display("FAIL init_done cycle %0d: got %b expected %b", cyc, init_done, (cyc >= DONE_CYC));
            end
            checks++;
            if ({ref_req, ref_pending, ref_overflow} !== 5'b0) begin
                errors++;
                $display("FAIL init_refresh_idle cycle %0d: got req %b pend %0d ovf %b", cyc, ref_req, ref_pending, ref_overflow);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL init_missing_cmds: got %0d left expected 0", exp_q.size());
        end
    endtask

    // Refresh phase: a behavioural model of the pending counter fills the
    // queue for every cycle up to last_c, then the DUT is stepped with the
    // ack plan and compared cycle by cycle.
    task automatic run_refresh(input int start_c, input int last_c);
        int            mp;
        bit            movf;
        bit            tk;
        bit            ak;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        mp   = 0;
        movf = 1'b0;
        ref_q.delete();
        for (int c = start_c + 1; c <= last_c; c++) begin
            tk = ((c - start_c) % T_REFI) == 0;
            ak = in_plan(c) && (mp != 0);
            if (tk && !ak) begin
                if (mp == PEND_MAX) movf = 1'b1;
                else mp++;
            end else if (ak && !tk) begin
                mp--;
            end
            ref_q.push_back({16'(c), 3'(mp), (mp != 0), movf});
        end

        while (cyc < last_c) begin
            ref_ack = in_plan(cyc + 1);
            step();
            ref_ack = 1'b0;
            exp = ref_q.pop_front();
            got = {16'(cyc), ref_pending, ref_req, ref_overflow};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL refresh cycle %0d: got pend %0d req %b ovf %b expected pend %0d req %b ovf %b",
                         cyc, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
            end
            checks++;
            if ({init_done, cmd_o} !== {1'b1, CMD_NOP}) begin
                errors++;
                $display("FAIL refresh_idle cycle %0d: got done %b cmd %b expected done 1 cmd %b", cyc, init_done, cmd_o, CMD_NOP);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({cke_o, cmd_o, addr_o, ba_o} !== {1'b0, CMD_INHIBIT, 13'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_pins: got cke %b cmd %b addr %h ba %b", cke_o, cmd_o, addr_o, ba_o);
        end
        checks++;
        if ({init_done, ref_req, ref_pending, ref_overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got done %b req %b pend %0d ovf %b", init_done, ref_req, ref_pending, ref_overflow);
        end
        checks++;
        if (dbg_state_o !== PWR_WAIT || dbg_wait_count_o !== '0) begin
            errors++;
            $display("FAIL reset_fsm: got state %0d count %0d expected 0 0", dbg_state_o, dbg_wait_count_o);
        end
    endtask

    task automatic test_init();
        apply_reset();
        run_init(1'b1);
    endtask

    task automatic test_refresh_no_ack();
        apply_reset();
        run_init(1'b0);
        ack_at.delete();
        run_refresh(cyc, DONE_CYC + 4 * T_REFI + 1);
    endtask

    // Tick+ack together, ack to zero, ack at zero, tick+ack at saturation,
    // then overflow.
    task automatic test_back_to_back();
        apply_reset();
        run_init(1'b0);
        ack_at.delete();
        ack_at.push_back(DONE_CYC + 2 * T_REFI);
        ack_at.push_back(DONE_CYC + 2 * T_REFI + 1);
        ack_at.push_back(DONE_CYC + 2 * T_REFI + 5);
        ack_at.push_back(DONE_CYC + 6 * T_REFI);
        run_refresh(cyc, DONE_CYC + 7 * T_REFI + 1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        while (cyc < 15) step();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({cke_o, cmd_o, addr_o, ba_o} !== {1'b0, CMD_INHIBIT, 13'd0, 2'b00}) begin
            errors++;
            $display("FAIL midreset_pins: got cke %b cmd %b addr %h ba %b", cke_o, cmd_o, addr_o, ba_o);
        end
        checks++;
        if ({init_done, ref_req, ref_pending, ref_overflow} !== 6'b0 || dbg_state_o !== PWR_WAIT) begin
            errors++;
            $display("FAIL midreset_status: got done %b req %b pend %0d ovf %b state %0d",
                     init_done, ref_req, ref_pending, ref_overflow, dbg_state_o);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
        run_init(1'b1);
        ack_at.delete();
        run_refresh(cyc, DONE_CYC + T_REFI + 1);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_init();
        test_refresh_no_ack();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
